// File: rtl/button_pio_event_master_if.sv
// Bus bundle between the button event master and its neighbours.
//   avm_*     : Avalon-MM master port toward the button PIO s1 slave
//   pio_irq   : PIO interrupt request (edge_capture & irq_mask != 0)
//   evt_*     : event record stream toward the ReCOP peripheral-input path
// The master modport is the event master's view; slave is the
// PIO/consumer side (used by whatever sits across the bus).
interface button_pio_event_master_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic             pio_irq;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_edges;
    logic [WIDTH-1:0] evt_level;
    logic             evt_overflow;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output evt_valid, evt_edges, evt_level, evt_overflow,
        input  avm_readdata, pio_irq, evt_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  evt_valid, evt_edges, evt_level, evt_overflow,
        output avm_readdata, pio_irq, evt_ready
    );
endinterface

// File: rtl/button_pio_event_master.sv
// Button PIO event master.
// Arms the button PIO's interrupt mask once after reset, then services the
// PIO whenever it raises pio_irq (and optionally on a periodic poll): reads
// edge_capture, clears it, reads the button levels, and publishes one event
// record per service with edges captured since the last clear.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : master modport of button_pio_event_master_if
//              (Avalon-MM to PIO s1, pio_irq, evt valid/ready record)
// Parameters:
//   WIDTH       : button count (1..32)
//   IRQ_MASK    : value written to PIO register 2 after reset
//   POLL_CYCLES : 0 = irq-driven only, N>0 = also service every N idle cycles
module button_pio_event_master #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK    = '1,
    parameter int               POLL_CYCLES = 0
) (
    input logic                        clk,
    input logic                        reset_n,
    button_pio_event_master_if.master  bus
);
    localparam logic [1:0]  REG_DATA  = 2'd0;
    localparam logic [1:0]  REG_MASK  = 2'd2;
    localparam logic [1:0]  REG_EDGE  = 2'd3;
    localparam logic [31:0] MASK_WORD = 32'(IRQ_MASK);

    localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0] POLL_LAST = (POLL_CYCLES > 0) ? CW'(POLL_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        INIT, IDLE, RD_EDGE, CLR, RD_LVL, LAT_LVL, POST
    } state_t;

    state_t           state;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [CW-1:0]    poll_cnt;
    logic [WIDTH-1:0] edge_tmp;
    logic [WIDTH-1:0] level_tmp;
    logic             valid;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] level;
    logic             overflow;
    logic             poll_hit;
    logic             accept;

    // Only the low WIDTH bits of readdata carry PIO state.
    logic unused_readdata;
    assign unused_readdata = &{1'b0, bus.avm_readdata};

    assign poll_hit = (POLL_CYCLES > 0) && (poll_cnt == POLL_LAST);
    assign accept   = valid && bus.evt_ready;

    // Bus outputs are loaded on entry to the state that owns them, so each
    // state's address/strobe is on the bus for exactly that state's cycle.
    // The PIO registers readdata one cycle after the address: RD_EDGE's read
    // lands in CLR, RD_LVL's read lands in LAT_LVL. INIT is the exception:
    // its mask write occupies the first IDLE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            address    <= REG_DATA;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
            poll_cnt   <= '0;
            edge_tmp   <= '0;
            level_tmp  <= '0;
            valid      <= 1'b0;
            edges      <= '0;
            level      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                valid    <= 1'b0;
                overflow <= 1'b0;
            end

            case (state)
                INIT: begin
                    address    <= REG_MASK;
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    writedata  <= MASK_WORD;
                    state      <= IDLE;
                end
                IDLE: begin
                    address    <= REG_EDGE;
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                    writedata  <= '0;
                    if (bus.pio_irq || poll_hit) begin
                        poll_cnt <= '0;
                        state    <= RD_EDGE;
                    end else begin
                        poll_cnt <= poll_cnt + CW'(1);
                    end
                end
                RD_EDGE: begin
                    // Clear write of edge_capture is on the bus during CLR.
                    // Edges arriving in RD_EDGE/CLR are lost to this clear.
                    address    <= REG_EDGE;
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    writedata  <= '0;
                    state      <= CLR;
                end
                CLR: begin
                    edge_tmp   <= bus.avm_readdata[WIDTH-1:0];
                    address    <= REG_DATA;
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                    state      <= RD_LVL;
                end
                RD_LVL: begin
                    state <= LAT_LVL;
                end
                LAT_LVL: begin
                    level_tmp <= bus.avm_readdata[WIDTH-1:0];
                    address   <= REG_EDGE;
                    state     <= POST;
                end
                POST: begin
                    // Services that found no edges (spurious irq, empty poll)
                    // leave the record untouched.
                    if (edge_tmp != '0) begin
                        if (!valid || bus.evt_ready) begin
                            edges    <= edge_tmp;
                            level    <= level_tmp;
                            overflow <= 1'b0;
                            valid    <= 1'b1;
                        end else begin
                            // Consumer is behind: fold this service into the
                            // pending record instead of stalling the PIO.
                            edges    <= edges | edge_tmp;
                            level    <= level_tmp;
                            overflow <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.avm_address    = address;
    assign bus.avm_chipselect = chipselect;
    assign bus.avm_write_n    = write_n;
    assign bus.avm_writedata  = writedata;
    assign bus.evt_valid      = valid;
    assign bus.evt_edges      = edges;
    assign bus.evt_level      = level;
    assign bus.evt_overflow   = overflow;
endmodule

// File: tb/tb_button_pio_event_master.sv
// Testbench for button_pio_event_master: two instances (irq-driven with full
// mask, poll-driven with mask 0), each attached to a behavioural button PIO
// (edge capture, clear-priority, registered readdata). Expected event records
// are queued when buttons are pressed and compared on acceptance.
module tb_button_pio_event_master;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    button_pio_event_master_if #(.WIDTH(4)) b0 ();
    button_pio_event_master_if #(.WIDTH(4)) b1 ();

    button_pio_event_master #(.WIDTH(4), .IRQ_MASK(4'hF), .POLL_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0));
    button_pio_event_master #(.WIDTH(4), .IRQ_MASK(4'h0), .POLL_CYCLES(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1));

    // ---------------- PIO models ----------------
    logic [3:0]  in0, d0, ec0, mask0;
    logic [3:0]  in1, d1, ec1, mask1;
    logic [31:0] rd0, rd1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d0 <= '0; ec0 <= '0; mask0 <= '0; rd0 <= '0;
        end else begin
            d0 <= in0;
            if (b0.avm_chipselect && !b0.avm_write_n && b0.avm_address == 2'd3) ec0 <= '0;
            else ec0 <= ec0 | (in0 & ~d0);
            if (b0.avm_chipselect && !b0.avm_write_n && b0.avm_address == 2'd2) mask0 <= b0.avm_writedata[3:0];
            case (b0.avm_address)
                2'd0:    rd0 <= {28'hFFFFFFF, in0};
                2'd2:    rd0 <= {28'hFFFFFFF, mask0};
                2'd3:    rd0 <= {28'hFFFFFFF, ec0};
                default: rd0 <= '0;
            endcase
        end
    end
    assign b0.avm_readdata = rd0;
    assign b0.pio_irq      = |(ec0 & mask0);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1 <= '0; ec1 <= '0; mask1 <= '0; rd1 <= '0;
        end else begin
            d1 <= in1;
            if (b1.avm_chipselect && !b1.avm_write_n && b1.avm_address == 2'd3) ec1 <= '0;
            else ec1 <= ec1 | (in1 & ~d1);
            if (b1.avm_chipselect && !b1.avm_write_n && b1.avm_address == 2'd2) mask1 <= b1.avm_writedata[3:0];
            case (b1.avm_address)
                2'd0:    rd1 <= {28'hFFFFFFF, in1};
                2'd2:    rd1 <= {28'hFFFFFFF, mask1};
                2'd3:    rd1 <= {28'hFFFFFFF, ec1};
                default: rd1 <= '0;
            endcase
        end
    end
    assign b1.avm_readdata = rd1;
    assign b1.pio_irq      = |(ec1 & mask1);

    // ---------------- scoreboard / monitors ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] q0[$];   // {edges, level, overflow}
    logic [8:0] q1[$];
    int wr0_mask = 0, wr0_clr = 0, wr0_other = 0;
    int wr1_mask = 0, wr1_clr = 0, wr1_other = 0;
    logic [31:0] wr0_mask_data = '0, wr1_mask_data = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (b0.avm_chipselect && !b0.avm_write_n) begin
                if (b0.avm_address == 2'd2) begin wr0_mask++; wr0_mask_data = b0.avm_writedata; end
                else if (b0.avm_address == 2'd3 && b0.avm_writedata == 0) wr0_clr++;
                else wr0_other++;
            end
            if (b0.evt_valid && b0.evt_ready) begin
                logic [8:0] e;
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL evt0_unexpected: got %b/%b/%b, expected no record",
                             b0.evt_edges, b0.evt_level, b0.evt_overflow);
                end else begin
                    e = q0.pop_front();
                    if ({b0.evt_edges, b0.evt_level, b0.evt_overflow} !== e) begin
                        n_fail++;
                        $display("FAIL evt0_record: got %b/%b/%b, expected %b/%b/%b",
                                 b0.evt_edges, b0.evt_level, b0.evt_overflow, e[8:5], e[4:1], e[0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (b1.avm_chipselect && !b1.avm_write_n) begin
                if (b1.avm_address == 2'd2) begin wr1_mask++; wr1_mask_data = b1.avm_writedata; end
                else if (b1.avm_address == 2'd3 && b1.avm_writedata == 0) wr1_clr++;
                else wr1_other++;
            end
            if (b1.evt_valid && b1.evt_ready) begin
                logic [8:0] e;
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL evt1_unexpected: got %b/%b/%b, expected no record",
                             b1.evt_edges, b1.evt_level, b1.evt_overflow);
                end else begin
                    e = q1.pop_front();
                    if ({b1.evt_edges, b1.evt_level, b1.evt_overflow} !== e) begin
                        n_fail++;
                        $display("FAIL evt1_record: got %b/%b/%b, expected %b/%b/%b",
                                 b1.evt_edges, b1.evt_level, b1.evt_overflow, e[8:5], e[4:1], e[0]);
                    end
                end
            end
        end
    end

    // {addr, cs, wr_n, wdata, valid, overflow, edges, level}
    localparam logic [46:0] RESET_VIEW = {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0};

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [46:0] v;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = {b0.avm_address, b0.avm_chipselect, b0.avm_write_n, b0.avm_writedata,
             b0.evt_valid, b0.evt_overflow, b0.evt_edges, b0.evt_level};
        n_checks++;
        if (v !== RESET_VIEW) begin n_fail++; $display("FAIL reset_outputs0: got %h, expected %h", v, RESET_VIEW); end
        v = {b1.avm_address, b1.avm_chipselect, b1.avm_write_n, b1.avm_writedata,
             b1.evt_valid, b1.evt_overflow, b1.evt_edges, b1.evt_level};
        n_checks++;
        if (v !== RESET_VIEW) begin n_fail++; $display("FAIL reset_outputs1: got %h, expected %h", v, RESET_VIEW); end
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (wr0_mask !== 1) begin n_fail++; $display("FAIL init_write_count0: got %0d, expected 1", wr0_mask); end
        n_checks++;
        if (wr0_mask_data !== 32'h0000_000F) begin n_fail++; $display("FAIL init_write_data0: got %h, expected 0000000f", wr0_mask_data); end
        n_checks++;
        if (wr0_clr !== 0 || wr0_other !== 0) begin n_fail++; $display("FAIL idle_writes0: got %0d clear + %0d other, expected 0", wr0_clr, wr0_other); end
        n_checks++;
        if (wr1_mask !== 1 || wr1_mask_data !== 32'h0) begin n_fail++; $display("FAIL init_write1: got %0d writes data %h, expected 1 write data 0", wr1_mask, wr1_mask_data); end
    endtask

    task automatic test_single_press();
        int cnt;
        int clr_before;
        clr_before = wr0_clr;
        @(posedge clk); #1;
        b0.evt_ready = 1'b1;
        q0.push_back({4'b0100, 4'b0100, 1'b0});
        in0 = 4'b0100;
        for (int i = 0; i < 10 && !b0.pio_irq; i++) @(negedge clk);
        n_checks++;
        if (!b0.pio_irq) begin n_fail++; $display("FAIL single_irq: got irq 0, expected 1 within 10 cycles"); end
        // irq first seen in an IDLE cycle; POST is 5 cycles later, valid the cycle after.
        cnt = 0;
        while (!b0.evt_valid && cnt < 20) begin @(negedge clk); cnt++; end
        n_checks++;
        if (cnt !== 6) begin n_fail++; $display("FAIL single_latency: got %0d cycles, expected 6 (irq cycle to valid)", cnt); end
        @(negedge clk);
        n_checks++;
        if (b0.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept: got valid %b, expected 0", b0.evt_valid); end
        n_checks++;
        if (wr0_clr - clr_before !== 1 || ec0 !== 4'b0) begin n_fail++; $display("FAIL single_clear: got %0d clears ec=%b, expected 1 clear ec=0000", wr0_clr - clr_before, ec0); end
        in0 = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_merge();
        @(posedge clk); #1;
        b0.evt_ready = 1'b0;
        in0 = 4'b0001;
        for (int i = 0; i < 20 && !b0.evt_valid; i++) @(negedge clk);
        n_checks++;
        if (b0.evt_valid !== 1'b1 || b0.evt_edges !== 4'b0001 || b0.evt_overflow !== 1'b0) begin
            n_fail++; $display("FAIL merge_first: got v=%b e=%b o=%b, expected v=1 e=0001 o=0", b0.evt_valid, b0.evt_edges, b0.evt_overflow);
        end
        repeat (3) @(negedge clk);
        in0 = 4'b1001;
        q0.push_back({4'b1001, 4'b1001, 1'b1});
        for (int i = 0; i < 20 && !b0.evt_overflow; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (b0.evt_valid !== 1'b1 || b0.evt_edges !== 4'b1001 || b0.evt_level !== 4'b1001 || b0.evt_overflow !== 1'b1) begin
            n_fail++; $display("FAIL merge_hold: got v=%b e=%b l=%b o=%b, expected v=1 e=1001 l=1001 o=1",
                               b0.evt_valid, b0.evt_edges, b0.evt_level, b0.evt_overflow);
        end
        @(posedge clk); #1;
        b0.evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (b0.evt_valid !== 1'b0 || b0.evt_overflow !== 1'b0) begin
            n_fail++; $display("FAIL merge_drop: got v=%b o=%b, expected 0/0", b0.evt_valid, b0.evt_overflow);
        end
        in0 = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_blind();
        int clr_before;
        logic seen;
        clr_before = wr0_clr;
        seen = 1'b0;
        @(posedge clk); #1;
        q0.push_back({4'b0001, 4'b0101, 1'b0});
        in0 = 4'b0001;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = b0.avm_chipselect && !b0.avm_write_n && b0.avm_address == 2'd3;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL blind_clr_seen: got no clear write, expected one within 20 cycles"); end
        in0 = 4'b0101;   // bit2 rises during the CLR cycle
        repeat (25) @(negedge clk);
        n_checks++;
        if (ec0 !== 4'b0 || b0.pio_irq !== 1'b0) begin n_fail++; $display("FAIL blind_capture: got ec=%b irq=%b, expected 0000/0", ec0, b0.pio_irq); end
        n_checks++;
        if (wr0_clr - clr_before !== 1 || b0.evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL blind_resvc: got %0d clears valid=%b, expected 1 clear valid=0", wr0_clr - clr_before, b0.evt_valid);
        end
        in0 = 4'b0000;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_poll();
        int vcnt;
        int clr_before;
        int cnt;
        logic seen;
        b1.evt_ready = 1'b1;
        clr_before = wr1_clr;
        vcnt = 0;
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (b1.evt_valid) vcnt++; end
        n_checks++;
        if (vcnt !== 0) begin n_fail++; $display("FAIL poll_idle_records: got %0d valid cycles, expected 0", vcnt); end
        n_checks++;
        if (wr1_mask !== 1 || wr1_other !== 0 || wr1_clr - clr_before < 2) begin
            n_fail++; $display("FAIL poll_idle_bus: got mask=%0d other=%0d polls=%0d, expected 1/0/>=2", wr1_mask, wr1_other, wr1_clr - clr_before);
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = b1.avm_chipselect && !b1.avm_write_n && b1.avm_address == 2'd3;
        end
        repeat (4) @(negedge clk);   // back in IDLE with the poll counter at 0
        q1.push_back({4'b0010, 4'b0010, 1'b0});
        in1 = 4'b0010;
        cnt = 0;
        while (!b1.evt_valid && cnt < 40) begin @(negedge clk); cnt++; end
        n_checks++;
        if (!b1.evt_valid || cnt > 21) begin n_fail++; $display("FAIL poll_latency: got %0d cycles valid=%b, expected <=21 and valid=1", cnt, b1.evt_valid); end
        repeat (3) @(negedge clk);
        in1 = 4'b0000;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int mask_before;
        int vcnt;
        logic seen;
        logic [46:0] v;
        mask_before = wr0_mask;
        seen = 1'b0;
        @(posedge clk); #1;
        in0 = 4'b0001;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = b0.avm_chipselect && !b0.avm_write_n && b0.avm_address == 2'd3;
        end
        @(negedge clk);   // RD_LVL cycle
        n_checks++;
        if (!seen || b0.avm_address !== 2'd0) begin n_fail++; $display("FAIL midrst_rdlvl: got seen=%b addr=%0d, expected 1/0", seen, b0.avm_address); end
        reset_n = 1'b0;
        in0 = 4'b0000;
        #1;
        v = {b0.avm_address, b0.avm_chipselect, b0.avm_write_n, b0.avm_writedata,
             b0.evt_valid, b0.evt_overflow, b0.evt_edges, b0.evt_level};
        n_checks++;
        if (v !== RESET_VIEW) begin n_fail++; $display("FAIL midrst_outputs: got %h, expected %h", v, RESET_VIEW); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 25; i++) begin @(negedge clk); if (b0.evt_valid) vcnt++; end
        n_checks++;
        if (wr0_mask - mask_before !== 1 || wr0_mask_data !== 32'h0000_000F) begin
            n_fail++; $display("FAIL midrst_rearm: got %0d mask writes data %h, expected 1 data 0000000f", wr0_mask - mask_before, wr0_mask_data);
        end
        n_checks++;
        if (vcnt !== 0) begin n_fail++; $display("FAIL midrst_stale: got %0d valid cycles, expected 0", vcnt); end
    endtask

    initial begin
        reset_n = 1'b0;
        in0 = '0;
        in1 = '0;
        b0.evt_ready = 1'b0;
        b1.evt_ready = 1'b0;
        test_reset();
        test_single_press();
        test_merge();
        test_blind();
        test_poll();
        test_reset_mid();
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d records outstanding, expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
